// File: rtl/aoc_dial_axil_slave_if.sv
// rtl/aoc_dial_axil_slave_if.sv - AXI4-Lite bus bundle for the dial accelerator slave
interface aoc_dial_axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aoc_dial_axil_slave.sv
// rtl/aoc_dial_axil_slave.sv - AXI4-Lite slave wrapping the AoC day-1 dial rotation engine
// Defining AOC_PASS_CNT_EN builds the click-through counter (PASS_CNT) at 0x10.
module aoc_dial_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int DIAL_SIZE          = 100,
  parameter int START_POS          = 50,
  parameter int AMT_WIDTH          = 16
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  aoc_dial_axil_slave_if.slave  s00_axi,
  output logic                  busy
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int POS_W = $clog2(DIAL_SIZE);
  localparam int EXT_W = AMT_WIDTH + 1;

  localparam logic [IDX_W-1:0]     IDX_ROT  = IDX_W'(0);
  localparam logic [IDX_W-1:0]     IDX_POS  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_ZERO = IDX_W'(2);
  localparam logic [IDX_W-1:0]     IDX_CTRL = IDX_W'(3);
  localparam logic [AMT_WIDTH-1:0] DIAL_AMT = AMT_WIDTH'(DIAL_SIZE);
  localparam logic [EXT_W-1:0]     DIAL_EXT = EXT_W'(DIAL_SIZE);
  localparam logic [POS_W-1:0]     START_P  = POS_W'(START_POS);
  localparam logic [DW-1:0]        ROT_MASK = {1'b1, {(DW-1-AMT_WIDTH){1'b0}}, {AMT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_APPLY
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 aw_ready_q;
  logic                 ar_ready_q;
  logic                 bvalid_q;
  logic                 rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic [DW-1:0]        rot_q;
  logic [DW-1:0]        rot_d;
  logic [DW-1:0]        rd_data;
  logic [AMT_WIDTH-1:0] rem_q;
  logic [POS_W-1:0]     pos_q;
  logic [POS_W-1:0]     pos_d;
  logic [31:0]          zero_cnt_q;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 clr_req;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [EXT_W-1:0]     pos_ext;
  logic [EXT_W-1:0]     rem_ext;
  logic [EXT_W-1:0]     sum_r;
  logic [EXT_W-1:0]     new_ext;
  logic                 wrap_r;
  logic                 unused_in;

`ifdef AOC_PASS_CNT_EN
  localparam logic [IDX_W-1:0] IDX_PASS = IDX_W'(4);
  logic [31:0] pass_cnt_q;
  logic        apply_pass;
`endif

  assign wr_idx  = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  // Ready is only raised once both AW and W are presented, so one handshake covers both.
  assign wr_acc  = aw_ready_q && s00_axi.awvalid && s00_axi.wvalid;
  assign rd_acc  = ar_ready_q && s00_axi.arvalid;
  assign clr_req = wr_acc && (wr_idx == IDX_CTRL) && s00_axi.wstrb[0] && s00_axi.wdata[1];

  assign unused_in = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  assign s00_axi.awready = aw_ready_q;
  assign s00_axi.wready  = aw_ready_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.arready = ar_ready_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign s00_axi.rvalid  = rvalid_q;
  assign busy            = busy_q;

  always_comb begin
    rot_d = rot_q;
    for (int b = 0; b < DW / 8; b++) begin
      if (s00_axi.wstrb[b]) begin
        rot_d[b*8 +: 8] = s00_axi.wdata[b*8 +: 8];
      end
    end
    rot_d = rot_d & ROT_MASK;
  end

  // rem is already below DIAL_SIZE here, so one correction step lands back in range.
  always_comb begin
    pos_ext = EXT_W'(pos_q);
    rem_ext = EXT_W'(rem_q);
    sum_r   = pos_ext + rem_ext;
    wrap_r  = (sum_r >= DIAL_EXT);
    if (rot_q[DW-1]) begin
      new_ext = (rem_ext > pos_ext) ? (pos_ext + DIAL_EXT - rem_ext) : (pos_ext - rem_ext);
    end else begin
      new_ext = wrap_r ? (sum_r - DIAL_EXT) : sum_r;
    end
    pos_d = POS_W'(new_ext);
  end

`ifdef AOC_PASS_CNT_EN
  always_comb begin
    apply_pass = 1'b0;
    if (rot_q[DW-1]) begin
      apply_pass = (pos_q != '0) && (rem_ext >= pos_ext);
    end else begin
      apply_pass = wrap_r;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      IDX_ROT:  rd_data = rot_q;
      IDX_POS:  rd_data = DW'(pos_q);
      IDX_ZERO: rd_data = DW'(zero_cnt_q);
      IDX_CTRL: rd_data = DW'(busy_q);
`ifdef AOC_PASS_CNT_EN
      IDX_PASS: rd_data = DW'(pass_cnt_q);
`endif
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      aw_ready_q <= !aw_ready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q && !busy_q;
      if (wr_acc) begin
        bvalid_q <= 1'b1;
      end else if (s00_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      ar_ready_q <= !ar_ready_q && s00_axi.arvalid && !rvalid_q;
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      rot_q      <= '0;
      rem_q      <= '0;
      pos_q      <= START_P;
      zero_cnt_q <= '0;
`ifdef AOC_PASS_CNT_EN
      pass_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_acc && (wr_idx == IDX_ROT)) begin
            rot_q   <= rot_d;
            rem_q   <= rot_d[AMT_WIDTH-1:0];
            state_q <= S_REDUCE;
            busy_q  <= 1'b1;
          end else if (clr_req) begin
            pos_q      <= START_P;
            zero_cnt_q <= '0;
`ifdef AOC_PASS_CNT_EN
            pass_cnt_q <= '0;
`endif
          end
        end
        S_REDUCE: begin
          if (rem_q >= DIAL_AMT) begin
            rem_q <= rem_q - DIAL_AMT;
`ifdef AOC_PASS_CNT_EN
            pass_cnt_q <= pass_cnt_q + 32'd1;
`endif
          end else begin
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          pos_q <= pos_d;
          if (pos_d == '0) begin
            zero_cnt_q <= zero_cnt_q + 32'd1;
          end
`ifdef AOC_PASS_CNT_EN
          pass_cnt_q <= pass_cnt_q + 32'(apply_pass);
`endif
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aoc_dial_axil_slave.sv
// tb/tb_aoc_dial_axil_slave.sv - scoreboard bench for the AoC dial AXI4-Lite slave
`timescale 1ns/1ps
module tb_aoc_dial_axil_slave;
`ifdef AOC_PASS_CNT_EN
  localparam bit PASS_EN = 1'b1;
`else
  localparam bit PASS_EN = 1'b0;
`endif
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int aw_busy_viol = 0;
  int busy_runs[$];
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  string       rq_name[$];
  logic [31:0] exp_r;
  string       nm;
  int          n0;

  logic [31:0] sample [10] = '{32'h8000_0044, 32'h8000_001E, 32'h0000_0030, 32'h8000_0005,
                               32'h0000_003C, 32'h8000_0037, 32'h8000_0001, 32'h8000_0063,
                               32'h0000_000E, 32'h8000_0052};

  aoc_dial_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) axi ();

  aoc_dial_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
    .DIAL_SIZE(100), .START_POS(50), .AMT_WIDTH(16)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi(axi),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic lost(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within %0d cycles", name, TO);
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is about to complete.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bresp_unexpected: got bvalid with empty scoreboard");
        end else begin
          check("bresp", 32'(axi.bresp), 32'(bq.pop_front()));
        end
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_unexpected: got rvalid with empty scoreboard");
        end else begin
          exp_r = rq.pop_front();
          nm = rq_name.pop_front();
          check(nm, axi.rdata, exp_r);
          check({nm, "_rresp"}, 32'(axi.rresp), 32'h0);
        end
      end
      if (busy && axi.awready) aw_busy_viol++;
      if (busy) begin
        run_len++;
      end else if (run_len != 0) begin
        busy_runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic wait_aw();
    int n = 0;
    @(negedge clk);
    while (!(axi.awready && axi.wready) && n < TO) begin @(negedge clk); n++; end
    if (!(axi.awready && axi.wready)) lost("aw_accept");
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!axi.bvalid && n < TO) begin @(negedge clk); n++; end
    if (!axi.bvalid) lost("b_valid");
  endtask

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!axi.arready && n < TO) begin @(negedge clk); n++; end
    if (!axi.arready) lost("ar_accept");
  endtask

  task automatic wait_r();
    int n = 0;
    @(negedge clk);
    while (!axi.rvalid && n < TO) begin @(negedge clk); n++; end
    if (!axi.rvalid) lost("r_valid");
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < TO) begin @(negedge clk); n++; end
    if (busy) lost("busy_fall");
  endtask

  task automatic wait_busy();
    int n = 0;
    @(negedge clk);
    while (!busy && n < TO) begin @(negedge clk); n++; end
    if (!busy) lost("busy_rise");
  endtask

  task automatic aw_issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk); #1;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bq.push_back(2'b00);
    aw_issue(addr, data, strb);
    wait_b();
    @(posedge clk); #1;
  endtask

  task automatic ar_issue(input logic [4:0] addr);
    @(posedge clk); #1;
    axi.araddr = addr; axi.arvalid = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
    rq.push_back(exp);
    rq_name.push_back(name);
    ar_issue(addr);
    wait_r();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_awready", 32'(axi.awready), 32'h0);
    check("rst_arready", 32'(axi.arready), 32'h0);
    check("rst_bvalid", 32'(axi.bvalid), 32'h0);
    check("rst_rvalid", 32'(axi.rvalid), 32'h0);
    check("rst_rdata", axi.rdata, 32'h0);
    axi_read(5'h00, 32'd0, "rst_rot");
    axi_read(5'h04, 32'd50, "rst_pos");
    axi_read(5'h08, 32'd0, "rst_zero");
    axi_read(5'h0C, 32'd0, "rst_ctrl");
    axi_read(5'h10, 32'd0, "rst_pass");

    for (int i = 0; i < 10; i++) axi_write(5'h00, sample[i], 4'hF);
    wait_idle();
    axi_read(5'h04, 32'd32, "sample_pos");
    axi_read(5'h08, 32'd3, "sample_zero");
    axi_read(5'h10, PASS_EN ? 32'd6 : 32'd0, "sample_pass");
    axi_read(5'h00, 32'h8000_0052, "sample_rot");
    axi_read(5'h1C, 32'd0, "unmapped_rd");

    axi_write(5'h0C, 32'h2, 4'b0010);
    axi_read(5'h04, 32'd32, "noclr_pos");
    axi_read(5'h08, 32'd3, "noclr_zero");
    axi_write(5'h0C, 32'h2, 4'b0001);
    axi_read(5'h04, 32'd50, "clr_pos");
    axi_read(5'h08, 32'd0, "clr_zero");
    axi_read(5'h10, 32'd0, "clr_pass");
    axi_read(5'h0C, 32'd0, "clr_ctrl");

    n0 = busy_runs.size();
    axi_write(5'h00, 32'h0000_03E8, 4'hF);
    wait_idle();
    axi_read(5'h04, 32'd50, "r1000_pos");
    axi_read(5'h08, 32'd0, "r1000_zero");
    axi_read(5'h10, PASS_EN ? 32'd10 : 32'd0, "r1000_pass");
    if (busy_runs.size() > n0) check("r1000_busy_cycles", busy_runs[n0], 32'd12);
    else lost("r1000_busy_run");

    n0 = busy_runs.size();
    fork
      begin
        axi_write(5'h00, 32'h0000_03E8, 4'hF);
        axi_write(5'h00, 32'h8000_0032, 4'hF);
      end
      begin
        wait_busy();
        axi_read(5'h0C, 32'd1, "ctrl_during_busy");
      end
    join
    wait_idle();
    axi_read(5'h04, 32'd0, "l50_pos");
    axi_read(5'h08, 32'd1, "l50_zero");
    axi_read(5'h10, PASS_EN ? 32'd21 : 32'd0, "l50_pass");
    if (busy_runs.size() > n0 + 1) begin
      check("r1000b_busy_cycles", busy_runs[n0], 32'd12);
      check("l50_busy_cycles", busy_runs[n0+1], 32'd2);
    end else lost("stall_busy_runs");

    axi.bready = 1'b0;
    bq.push_back(2'b00);
    aw_issue(5'h14, 32'hDEAD_BEEF, 4'hF);
    wait_b();
    @(posedge clk); #1;
    axi.awaddr = 5'h18; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    bq.push_back(2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(axi.bvalid), 32'h1);
      check("bresp_hold", 32'(axi.bresp), 32'h0);
      check("awready_hold", 32'(axi.awready), 32'h0);
    end
    @(posedge clk); #1;
    axi.bready = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    wait_b();
    @(posedge clk); #1;

    axi.rready = 1'b0;
    rq.push_back(32'd1); rq_name.push_back("zero_hold");
    ar_issue(5'h08);
    wait_r();
    @(posedge clk); #1;
    axi.araddr = 5'h04; axi.arvalid = 1'b1;
    rq.push_back(32'd0); rq_name.push_back("pos_after_hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(axi.rvalid), 32'h1);
      check("rdata_hold", axi.rdata, 32'd1);
      check("arready_hold", 32'(axi.arready), 32'h0);
    end
    @(posedge clk); #1;
    axi.rready = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    wait_r();
    @(posedge clk); #1;

    axi.bready = 1'b0;
    aw_issue(5'h00, 32'h0000_03E8, 4'hF);
    wait_b();
    @(posedge clk); #1;
    check("busy_before_rst", 32'(busy), 32'h1);
    check("bvalid_before_rst", 32'(axi.bvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("busy_in_rst", 32'(busy), 32'h0);
    check("bvalid_in_rst", 32'(axi.bvalid), 32'h0);
    check("rvalid_in_rst", 32'(axi.rvalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axi.bready = 1'b1;
    axi_read(5'h04, 32'd50, "post_rst_pos");
    axi_read(5'h08, 32'd0, "post_rst_zero");
    axi_read(5'h00, 32'd0, "post_rst_rot");

    axi_write(5'h00, 32'h8000_00FF, 4'b0001);
    wait_idle();
    axi_read(5'h00, 32'h0000_00FF, "strb_rot_lo");
    axi_read(5'h04, 32'd5, "strb_pos_r255");
    axi_write(5'h00, 32'h8000_0000, 4'b1000);
    wait_idle();
    axi_read(5'h00, 32'h8000_00FF, "strb_rot_hi");
    axi_read(5'h04, 32'd50, "strb_pos_l255");
    axi_read(5'h10, PASS_EN ? 32'd6 : 32'd0, "strb_pass");

    check("awready_while_busy", 32'(aw_busy_viol), 32'h0);
    check("bq_drained", 32'(bq.size()), 32'h0);
    check("rq_drained", 32'(rq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
